mod_74x32_3_or: RTL and testbench

//   Three-gate slice of a 74x32 quad 2-input OR: Y[i] = A[i] | B[i], one gate per bit.

---
 rtl/mod_74x32_3_or.sv | 59 +++++
 tb/tb_mod_74x32_3_or.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mod_74x32_3_or.sv
// mod_74x32_3_or: 74x32 OR-gate slice with a reset-clearable output pipeline
module mod_74x32_or_cell #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic y
);
  generate
    if (LATENCY == 0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign y = a | b;
    end else begin : g_reg
      logic [LATENCY-1:0] q;
      always_ff @(posedge clk) q <= rst ? '0 : (q << 1) | LATENCY'(a | b);
      assign y = q[LATENCY-1];
    end
  endgenerate
endmodule

module mod_74x32_3_or #(
  parameter int GATES   = 3,
  parameter int LATENCY = 1,
  parameter bit SPLIT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:GATES-1] A,
  input  logic [0:GATES-1] B,
  output logic [0:GATES-1] Y
);
  generate
    if (SPLIT) begin : g_split
      for (genvar i = 0; i < GATES; i++) begin : g_gate
        mod_74x32_or_cell #(.LATENCY(LATENCY)) u_cell (
          .clk(clk),
          .rst(rst),
          .a  (A[i]),
          .b  (B[i]),
          .y  (Y[i])
        );
      end
    end else if (LATENCY == 0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign Y = A | B;
    end else begin : g_pipe
      logic [0:GATES-1] stage [LATENCY];
      always_ff @(posedge clk) begin
        stage[0] <= rst ? '0 : A | B;
        for (int s = 1; s < LATENCY; s++) stage[s] <= rst ? '0 : stage[s-1];
      end
      assign Y = stage[LATENCY-1];
    end
  endgenerate
endmodule

// File: tb/tb_mod_74x32_3_or.sv
// tb_mod_74x32_3_or: scoreboard bench for the OR slice across latency and split variants
module tb_mod_74x32_3_or;
  logic clk = 0;
  logic rst = 1;
  logic [0:2] a = '0;
  logic [0:2] b = '0;
  logic [0:2] y1, y3, yc, ycs, ys0, ys1;
  logic [0:2] q1[$];
  logic [0:2] q3[$];
  logic [0:2] q2[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_74x32_3_or dut1 (.clk(clk), .rst(rst), .A(a), .B(b), .Y(y1));
  mod_74x32_3_or #(.LATENCY(3)) dut3 (.clk(clk), .rst(rst), .A(a), .B(b), .Y(y3));
  mod_74x32_3_or #(.LATENCY(0)) dut_c (.clk(clk), .rst(rst), .A(a), .B(b), .Y(yc));
  mod_74x32_3_or #(.LATENCY(0), .SPLIT(1)) dut_cs (.clk(clk), .rst(rst), .A(a), .B(b), .Y(ycs));
  mod_74x32_3_or #(.LATENCY(2), .SPLIT(0)) dut_v (.clk(clk), .rst(rst), .A(a), .B(b), .Y(ys0));
  mod_74x32_3_or #(.LATENCY(2), .SPLIT(1)) dut_s (.clk(clk), .rst(rst), .A(a), .B(b), .Y(ys1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    a = 3'b111;
    b = 3'b111;
    tick();
    tick();
    checks++; if (y1 !== 3'b000) begin failures++; $display("FAIL reset_y1 got=%b exp=000", y1); end
    checks++; if (y3 !== 3'b000) begin failures++; $display("FAIL reset_y3 got=%b exp=000", y3); end
    checks++; if (ys0 !== 3'b000) begin failures++; $display("FAIL reset_ys0 got=%b exp=000", ys0); end
    checks++; if (ys1 !== 3'b000) begin failures++; $display("FAIL reset_ys1 got=%b exp=000", ys1); end
    checks++; if (yc !== 3'b111) begin failures++; $display("FAIL reset_comb got=%b exp=111", yc); end
  endtask

  task automatic test_basic;
    logic [0:2] va [7] = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b101, 3'b100, 3'b010};
    logic [0:2] vb [7] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b010, 3'b000, 3'b000};
    logic [0:2] ve [7] = '{3'b111, 3'b111, 3'b111, 3'b000, 3'b111, 3'b100, 3'b010};
    logic [0:2] e;
    rst = 0;
    for (int i = 0; i < 7; i++) begin
      a = va[i];
      b = vb[i];
      #1;
      checks++; if (yc !== ve[i]) begin failures++; $display("FAIL comb_vec%0d got=%b exp=%b", i, yc, ve[i]); end
      checks++; if (ycs !== ve[i]) begin failures++; $display("FAIL comb_split_vec%0d got=%b exp=%b", i, ycs, ve[i]); end
      repeat (2) begin
        q1.push_back(rst ? 3'b000 : ve[i]);
        tick();
        e = q1.pop_front();
        checks++; if (y1 !== e) begin failures++; $display("FAIL basic_vec%0d got=%b exp=%b", i, y1, e); end
      end
      if (i == 5) begin
        checks++; if (y1[0] !== 1'b1 || y1[1] !== 1'b0) begin failures++; $display("FAIL bit_order got=%b exp=100", y1); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [0:2] e;
    a = 3'b111;
    b = 3'b000;
    q1.push_back(3'b111);
    tick();
    e = q1.pop_front();
    checks++; if (y1 !== e) begin failures++; $display("FAIL mid_pre got=%b exp=%b", y1, e); end
    rst = 1;
    q1.push_back(3'b000);
    tick();
    e = q1.pop_front();
    checks++; if (y1 !== e) begin failures++; $display("FAIL mid_rst got=%b exp=%b", y1, e); end
    checks++; if (y3 !== 3'b000) begin failures++; $display("FAIL mid_rst_y3 got=%b exp=000", y3); end
    rst = 0;
    q1.push_back(3'b111);
    tick();
    e = q1.pop_front();
    checks++; if (y1 !== e) begin failures++; $display("FAIL mid_release got=%b exp=%b", y1, e); end
  endtask

  task automatic test_latency;
    logic [0:2] e;
    int first = 0;
    rst = 1;
    a = 3'b000;
    b = 3'b000;
    tick();
    rst = 0;
    q3.delete();
    q3.push_back(3'b000);
    q3.push_back(3'b000);
    q3.push_back(3'b000);
    tick();
    e = q3.pop_front();
    checks++; if (y3 !== e) begin failures++; $display("FAIL lat_idle got=%b exp=%b", y3, e); end
    a = 3'b001;
    for (int k = 1; k <= 6; k++) begin
      q3.push_back(3'b001);
      tick();
      e = q3.pop_front();
      checks++; if (y3 !== e) begin failures++; $display("FAIL lat_edge%0d got=%b exp=%b", k, y3, e); end
      if (first == 0 && y3 === 3'b001) first = k;
    end
    checks++; if (first !== 3) begin failures++; $display("FAIL lat_first_edge got=%0d exp=3", first); end
  endtask

  task automatic test_equiv;
    logic [0:2] e;
    rst = 1;
    tick();
    rst = 0;
    q2.delete();
    q2.push_back(3'b000);
    for (int n = 0; n < 200; n++) begin
      a = 3'($urandom);
      b = 3'($urandom);
      rst = ($urandom_range(0, 19) == 0);
      if (rst) foreach (q2[j]) q2[j] = 3'b000;
      q2.push_back(rst ? 3'b000 : a | b);
      tick();
      e = q2.pop_front();
      checks++; if (ys0 !== e) begin failures++; $display("FAIL equiv_vec_c%0d got=%b exp=%b", n, ys0, e); end
      checks++; if (ys1 !== e) begin failures++; $display("FAIL equiv_split_c%0d got=%b exp=%b", n, ys1, e); end
      checks++; if (ys1 !== ys0) begin failures++; $display("FAIL equiv_pair_c%0d split=%b vec=%b", n, ys1, ys0); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_latency();
    test_equiv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
